// File: rtl/axi_lite_stream_master.sv
// AXI4-Lite master fed by an ordered command stream, returning an ordered response stream.
// Optional watchdog: define AXIL_TIMEOUT_EN to build the sticky timeout counter.
module axi_lite_stream_master #(
    parameter int DATA_WD     = 32,
    parameter int ADDR_WD     = 32,
    parameter int STRB_WD     = DATA_WD / 8,
    parameter int MAX_OUTST   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rstn,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_rd,
    input  logic [ADDR_WD-1:0] cmd_addr,
    input  logic [DATA_WD-1:0] cmd_data,
    input  logic [STRB_WD-1:0] cmd_strb,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_rd,
    output logic [DATA_WD-1:0] rsp_data,
    output logic [1:0]         rsp_resp,

    output logic               err,
    input  logic               err_clr,
    output logic               busy,
    output logic               timeout,

    output logic [ADDR_WD-1:0] awaddr,
    output logic [2:0]         awprot,
    output logic               awvalid,
    input  logic               awready,

    output logic [DATA_WD-1:0] wdata,
    output logic [STRB_WD-1:0] wstrb,
    output logic               wvalid,
    input  logic               wready,

    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready,

    output logic [ADDR_WD-1:0] araddr,
    output logic [2:0]         arprot,
    output logic               arvalid,
    input  logic               arready,

    input  logic [DATA_WD-1:0] rdata,
    input  logic [1:0]         rresp,
    input  logic               rvalid,
    output logic               rready
);

    localparam int                CNT_WD  = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_WD-1:0] MAX_CNT = CNT_WD'(MAX_OUTST);

    logic [CNT_WD-1:0] outst;
    logic              dir;
    logic              cmd_fire;
    logic              b_fire;
    logic              r_fire;
    logic              rsp_fire;
    logic [1:0]        fire_resp;
    logic              slots_free;
    logic              cap_ok;
    logic              dir_ok;

    assign awprot = 3'b000;
    assign arprot = 3'b000;

    // Responses are only accepted when the response register can take them.
    assign bready = (!rsp_valid || rsp_ready) && !dir && (outst != '0);
    assign rready = (!rsp_valid || rsp_ready) &&  dir && (outst != '0);

    assign b_fire    = bvalid && bready;
    assign r_fire    = rvalid && rready;
    assign rsp_fire  = b_fire || r_fire;
    assign fire_resp = b_fire ? bresp : rresp;
    assign cmd_fire  = cmd_valid && cmd_ready;

    // NOTE: always_comb assigns every output on every path so no latch can be inferred.
    always_comb begin
        slots_free = cmd_rd ? (!arvalid || arready)
                            : ((!awvalid || awready) && (!wvalid || wready));
        // A response firing this cycle frees a slot for a command in the same cycle.
        cap_ok     = (outst < MAX_CNT) || rsp_fire;
        // Staying in one direction keeps responses in issue order without tags.
        dir_ok     = (outst == '0) || (cmd_rd == dir);
        cmd_ready  = cap_ok && dir_ok && slots_free;
    end

    assign busy = (outst != '0) || awvalid || wvalid || arvalid;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outst <= '0;
            dir   <= 1'b0;
        end else begin
            if (cmd_fire) begin
                dir <= cmd_rd;
            end
            case ({cmd_fire, rsp_fire})
                2'b10:   outst <= outst + CNT_WD'(1);
                2'b01:   outst <= outst - CNT_WD'(1);
                default: outst <= outst;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            awaddr  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
        end else if (cmd_fire && !cmd_rd) begin
            awaddr  <= cmd_addr;
            wdata   <= cmd_data;
            wstrb   <= cmd_strb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
        end else begin
            if (awready) begin
                awvalid <= 1'b0;
            end
            if (wready) begin
                wvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            araddr  <= '0;
            arvalid <= 1'b0;
        end else if (cmd_fire && cmd_rd) begin
            araddr  <= cmd_addr;
            arvalid <= 1'b1;
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid <= 1'b0;
            rsp_rd    <= 1'b0;
            rsp_data  <= '0;
            rsp_resp  <= 2'b00;
        end else if (b_fire) begin
            rsp_valid <= 1'b1;
            rsp_rd    <= 1'b0;
            rsp_data  <= '0;
            rsp_resp  <= bresp;
        end else if (r_fire) begin
            rsp_valid <= 1'b1;
            rsp_rd    <= 1'b1;
            rsp_data  <= rdata;
            rsp_resp  <= rresp;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Setting has priority over clearing so no error response is ever lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if (rsp_fire && (fire_resp != 2'b00)) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

`ifdef AXIL_TIMEOUT_EN
    localparam int                TMO_WD  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_WD-1:0] TMO_MAX = TMO_WD'(TIMEOUT_CYC - 1);

    logic [TMO_WD-1:0] tmo_cnt;
    logic [TMO_WD-1:0] tmo_nxt;
    logic              tmo_hit;

    always_comb begin
        tmo_nxt = tmo_cnt;
        if (rsp_fire || (outst == '0)) begin
            tmo_nxt = '0;
        end else if (tmo_cnt != TMO_MAX) begin
            tmo_nxt = tmo_cnt + TMO_WD'(1);
        end
        // Flag only on the transition to the limit so err_clr is not immediately undone.
        tmo_hit = (outst != '0) && !rsp_fire && (tmo_cnt != TMO_MAX) && (tmo_nxt == TMO_MAX);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            tmo_cnt <= tmo_nxt;
            if (tmo_hit) begin
                timeout <= 1'b1;
            end else if (err_clr) begin
                timeout <= 1'b0;
            end
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_stream_master.sv
// Directed bench for axi_lite_stream_master: vector table of single transactions plus
// hand-written multi-cycle sequences (ordering, back-pressure, caps, err, timeout).
module tb_axi_lite_stream_master;

    logic        clk;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_rd;
    logic [31:0] cmd_addr, cmd_data;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_rd;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        err, err_clr, busy, timeout;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;

    int n_chk  = 0;
    int n_fail = 0;

    axi_lite_stream_master #(
        .DATA_WD(32), .ADDR_WD(32), .MAX_OUTST(4), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .err(err), .err_clr(err_clr), .busy(busy), .timeout(timeout),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdat;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Presents one command, waits (bounded) for acceptance, returns in the cycle after the fire.
    task automatic issue(input logic rd, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_strb  = strb;
        settle();
        while (!cmd_ready && n < 50) begin
            step();
            settle();
            n++;
        end
        check("cmd_accept", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int          cnt;
        int          issued;
        int          got;
        int          wait_cnt;
        bit          stall_seen;
        bit          free_seen;
        logic [31:0] ar_q[$];

        vecs[0] = '{1'b0, 32'h0000_0010, 32'hA5A5_A5A5, 4'b0011, 2'b00, 32'h0, 32'h0,         2'b00, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h0,         4'b0000, 2'b00, 32'h1234_5678, 32'h1234_5678, 2'b00, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0044, 32'hCAFE_F00D, 4'b1111, 2'b10, 32'h0, 32'h0,         2'b10, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0080, 32'h0,         4'b0000, 2'b11, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11, 1'b1};
        vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'b1000, 2'b01, 32'h0, 32'h0,         2'b01, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0000, 32'h0,         4'b0000, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b0};

        rstn = 1'b0;
        cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
        rsp_ready = 1'b0; err_clr = 1'b0;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rdata = '0; rresp = 2'b00;

        repeat (3) step();
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_addr_data", {awaddr, araddr}, 64'h0);
        check("rst_wdata_wstrb", {wdata, wstrb}, 36'h0);
        check("prot", {awprot, arprot}, 6'h0);
        rstn = 1'b1;
        step();
        settle();
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // Single transactions, slave always ready.
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].strb);
            settle();
            if (vecs[i].rd) begin
                check("v_arvalid", arvalid, 1'b1);
                check("v_araddr", araddr, vecs[i].addr);
            end else begin
                check("v_aw_w_valid", {awvalid, wvalid}, 2'b11);
                check("v_awaddr", awaddr, vecs[i].addr);
                check("v_wdata", wdata, vecs[i].data);
                check("v_wstrb", wstrb, vecs[i].strb);
            end
            check("v_busy", busy, 1'b1);
            step();
            if (vecs[i].rd) begin
                rvalid = 1'b1; rdata = vecs[i].rdat; rresp = vecs[i].resp;
            end else begin
                bvalid = 1'b1; bresp = vecs[i].resp;
                rdata = 32'h5A5A_5A5A; rresp = 2'b11;
            end
            settle();
            check("v_resp_ready", vecs[i].rd ? rready : bready, 1'b1);
            check("v_req_done", {awvalid, wvalid, arvalid}, 3'b000);
            step();
            bvalid = 1'b0; rvalid = 1'b0;
            settle();
            check("v_rsp_valid", rsp_valid, 1'b1);
            check("v_rsp_rd", rsp_rd, vecs[i].rd);
            check("v_rsp_data", rsp_data, vecs[i].exp_data);
            check("v_rsp_resp", rsp_resp, vecs[i].exp_resp);
            check("v_err", err, vecs[i].exp_err);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0; err_clr = 1'b1;
            settle();
            check("v_rsp_taken", rsp_valid, 1'b0);
            check("v_idle", busy, 1'b0);
            step();
            err_clr = 1'b0;
            settle();
            check("v_err_clr", err, 1'b0);
        end

        // W accepted three cycles before AW.
        awready = 1'b0; wready = 1'b1; rsp_ready = 1'b0;
        issue(1'b0, 32'h0000_0030, 32'h0F0F_0F0F, 4'b0101);
        settle();
        check("split_both_valid", {awvalid, wvalid}, 2'b11);
        step();
        settle();
        check("split_w_done", {awvalid, wvalid}, 2'b10);
        check("split_cmd_blocked", cmd_ready, 1'b0);
        check("split_awaddr_held", awaddr, 32'h0000_0030);
        step();
        step();
        awready = 1'b1;
        settle();
        check("split_aw_waiting", awvalid, 1'b1);
        step();
        settle();
        check("split_aw_done", awvalid, 1'b0);
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0; rsp_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            settle();
            if (rsp_valid) cnt++;
            step();
        end
        check("split_one_rsp", cnt, 1);

        // Six back-to-back reads against a slow R channel.
        issued = 0; got = 0; wait_cnt = 0; stall_seen = 0; free_seen = 0;
        rsp_ready = 1'b1; arready = 1'b1;
        for (int cyc = 0; cyc < 300 && got < 6; cyc++) begin
            cmd_valid = (issued < 6);
            cmd_rd    = 1'b1;
            cmd_addr  = 32'h0000_0100 + 32'(issued * 4);
            rvalid    = (ar_q.size() != 0) && (wait_cnt >= 5);
            rdata     = rvalid ? (32'hB000_0000 | ar_q[0]) : 32'h0;
            rresp     = 2'b00;
            settle();
            if (rsp_valid) begin
                check("burst_order", rsp_data, 32'hB000_0100 + 32'(got * 4));
                got++;
            end
            if (cmd_valid && !cmd_ready && !stall_seen) begin
                stall_seen = 1;
                check("burst_cap", issued, 4);
            end
            if (rvalid && rready && !free_seen && issued < 6) begin
                free_seen = 1;
                check("burst_freed_slot", cmd_ready, 1'b1);
            end
            if (cmd_valid && cmd_ready) issued++;
            if (arvalid && arready) ar_q.push_back(araddr);
            if (rvalid && rready) begin
                void'(ar_q.pop_front());
                wait_cnt = 0;
            end else if (ar_q.size() != 0) begin
                wait_cnt++;
            end
            step();
        end
        cmd_valid = 1'b0; rvalid = 1'b0;
        check("burst_all_rsp", got, 6);
        check("burst_stall_seen", stall_seen, 1'b1);
        step();

        // Read behind two outstanding writes.
        rsp_ready = 1'b1; awready = 1'b1; wready = 1'b1;
        issue(1'b0, 32'h0000_0040, 32'h1111_0000, 4'b1111);
        issue(1'b0, 32'h0000_0044, 32'h2222_0000, 4'b1111);
        cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_addr = 32'h0000_0048;
        settle();
        check("dirchg_blocked0", cmd_ready, 1'b0);
        step();
        bvalid = 1'b1; bresp = 2'b00;
        settle();
        check("dirchg_blocked_b1", cmd_ready, 1'b0);
        step();
        settle();
        check("dirchg_blocked_b2", {cmd_ready, arvalid}, 2'b00);
        step();
        bvalid = 1'b0;
        settle();
        check("dirchg_ready", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        settle();
        check("dirchg_arvalid", arvalid, 1'b1);
        check("dirchg_araddr", araddr, 32'h0000_0048);
        step();
        rvalid = 1'b1; rdata = 32'h0000_4848; rresp = 2'b00;
        step();
        rvalid = 1'b0;
        settle();
        check("dirchg_rsp", {rsp_valid, rsp_rd, rsp_data}, {2'b11, 32'h0000_4848});
        step();

        // Response back-pressure holds data and blocks R.
        rsp_ready = 1'b0;
        issue(1'b1, 32'h0000_0200, 32'h0, 4'b0);
        issue(1'b1, 32'h0000_0204, 32'h0, 4'b0);
        step();
        rvalid = 1'b1; rdata = 32'h1111_1111; rresp = 2'b00;
        settle();
        check("bp_rready_free", rready, 1'b1);
        step();
        rdata = 32'hDEAD_BEEF;
        settle();
        check("bp_rready_blocked", rready, 1'b0);
        check("bp_first_data", rsp_data, 32'h1111_1111);
        step();
        settle();
        check("bp_data_held", {rsp_valid, rready, rsp_data}, {2'b10, 32'h1111_1111});
        rsp_ready = 1'b1;
        settle();
        check("bp_release_rready", rready, 1'b1);
        step();
        rvalid = 1'b0;
        settle();
        check("bp_second_data", {rsp_valid, rsp_data}, {1'b1, 32'hDEAD_BEEF});
        step();
        settle();
        check("bp_delivered_once", rsp_valid, 1'b0);

        // SLVERR sets err, err_clr clears it, and a same-cycle set wins over clear.
        issue(1'b1, 32'h0000_0300, 32'h0, 4'b0);
        step();
        rvalid = 1'b1; rdata = 32'h0; rresp = 2'b10;
        step();
        rvalid = 1'b0;
        settle();
        check("err_set", {err, rsp_resp}, 3'b110);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        settle();
        check("err_cleared", err, 1'b0);
        issue(1'b1, 32'h0000_0304, 32'h0, 4'b0);
        step();
        rvalid = 1'b1; rresp = 2'b01; err_clr = 1'b1;
        step();
        rvalid = 1'b0; err_clr = 1'b0;
        settle();
        check("err_set_wins", err, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        settle();
        check("err_cleared2", err, 1'b0);
        check("idle_before_tmo", busy, 1'b0);

        // A write whose B never returns.
        issue(1'b0, 32'h0000_0400, 32'h0000_00AA, 4'b0001);
        repeat (14) step();
        settle();
        check("tmo_early", timeout, 1'b0);
        step();
        settle();
`ifdef AXIL_TIMEOUT_EN
        check("tmo_fired", timeout, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        settle();
        check("tmo_cleared", timeout, 1'b0);
`else
        check("tmo_absent", timeout, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
